ping_echo_meter: RTL and testbench
==================================

# ping_echo_meter

Controls one transmit burst of the phase-ping front end and measures the echo that the digitizer returns. A start strobe (the UART receive strobe) launches a fixed-length burst enable to the PLL-driven transmit pad. The block then watches the 1-bit digitized comparator stream for rising edges within a listen window. It reports first-edge time-of-flight and edge count to the hex dump / status path as one valid-qualified result.

## Interface
Parameters:
- `BURST_LEN`, default 512: cycles `tx_en` is held high.
- `WIN`, default 2048: total cycles per measurement (burst + listen); power of two, greater than `BURST_LEN + BLANK`.
- `BLANK`, default 64: cycles at the start of listen during which edges are ignored (only with the macro).
- `CNT_W`, default `$clog2(WIN)`: counter/result width.

Ports:
- `clk`, in, 1: system clock (48 MHz).
- `rst`, in, 1: reset; synchronous, active-high.
- `start`, in, 1: one-cycle launch strobe.
- `sig`, in, 1: digitized echo, already synchronous to `clk`.
- `tx_en`, out, 1: burst enable to the transmit pad OE.
- `busy`, out, 1: high from the cycle after an accepted start until the report cycle ends.
- `result`, out, CNT_W: counter value at the first qualified rising edge; all-ones on timeout.
- `edge_cnt`, out, 8: qualified rising edges in the window, saturating at 255.
- `timeout`, out, 1: no qualified edge in the last window.
- `result_valid`, out, 1: one-cycle strobe; `result`, `edge_cnt` and `timeout` are valid and held until the next report.

## Operation
- FSM states: IDLE, BURST, LISTEN, REPORT.
- IDLE:
  - `start` = 1 goes to BURST.
  - On entry to BURST: counter = 0, first-edge flag clear, `edge_cnt` working copy = 0.
- BURST:
  - `tx_en` = 1 and the counter increments.
  - When counter = BURST_LEN-1, go to LISTEN.
- LISTEN:
  - `tx_en` = 0 and the counter increments.
  - Rising edge means `sig` = 1 and the previous-cycle `sig` = 0. The edge register updates every cycle in every state.
  - A qualified edge captures the counter value the first time and increments the edge count.
  - When counter = WIN-1, go to REPORT.
  - An edge in the WIN-1 cycle is still counted and captured.
- REPORT:
  - Publish the outputs and pulse `result_valid`.
  - No qualified edge gives `result` = all-ones and `timeout` = 1.
  - Go to IDLE.
- Edges during BURST or IDLE are never counted.
- `sig` high across the BURST-to-LISTEN boundary does not produce an edge.
- `start` outside IDLE is ignored; there is no queueing.
- Edge count saturates at 255.
- Counter arithmetic is unsigned CNT_W bits and never wraps within a measurement.

## Timing
- Reset values: `tx_en`, `busy`, `timeout` and `result_valid` are 0; `result` and `edge_cnt` are 0; state is IDLE.
- With `start` sampled at cycle T:
  - `tx_en` is high for cycles T+1 through T+BURST_LEN.
  - LISTEN covers cycles T+BURST_LEN+1 through T+WIN.
  - `result_valid` is high in cycle T+WIN+1.
  - `busy` = 0 from T+WIN+2.
- A new `start` is accepted at the earliest in cycle T+WIN+2.
- `rst` mid-operation: the next cycle is IDLE with all outputs at reset values, and no `result_valid` is issued.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `PING_BLANK_EN` defined: edges with counter < BURST_LEN+BLANK are not qualified. This suppresses direct coupling ringing. The edge register still tracks `sig`.
- `PING_BLANK_EN` undefined: every LISTEN edge qualifies, and `BLANK` is unused.

## Structure
- Package `ping_pkg`:
  - state enum (IDLE/BURST/LISTEN/REPORT);
  - default constants for `BURST_LEN`, `WIN`, `BLANK`;
  - edge-count width 8 and saturation value 255.
- Sub-module `rise_detect`: one-register rising-edge detector (`clk`, `rst`, `d`, `rise`), reset value 0.

## Test plan
Bench parameters: BURST_LEN=16, WIN=64, BLANK=4, CNT_W=6.
1. `start` at T; `sig` rises at counter 30 -> `tx_en` high T+1..T+16; `result_valid` at T+65 with `result`=30, `edge_cnt`=1, `timeout`=0.
2. `start`; `sig` stays 0 -> `result`=63, `timeout`=1, `edge_cnt`=0; `busy` low from T+66.
3. Single edge at counter 18 -> with `PING_BLANK_EN`: `timeout`=1, `edge_cnt`=0; without it: `result`=18, `edge_cnt`=1.
4. Edges at counters 20, 30, 40, 63; extra `start` pulses at counters 5 and 50 -> `result`=20, `edge_cnt`=4, exactly one `result_valid`.
5. `rst` at counter 10 -> next cycle `tx_en`=0, `busy`=0, no `result_valid`; a following `start` runs case 1 correctly.
6. `sig` high from counter 12 to the end of the window -> no rising edge, `timeout`=1.

Source files
------------

// File: rtl/ping_pkg.sv
// Shared types and defaults for the ping burst / echo measurement block.
package ping_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int DEF_BURST_LEN = 512;
  localparam int DEF_WIN       = 2048;
  localparam int DEF_BLANK     = 64;

  localparam int               EDGE_W   = 8;
  localparam logic [EDGE_W-1:0] EDGE_SAT = 8'd255;

  // Edge counter increment that sticks at the saturation value.
  function automatic logic [EDGE_W-1:0] edge_inc(input logic [EDGE_W-1:0] c);
    return (c == EDGE_SAT) ? c : c + EDGE_W'(1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-register rising-edge detector; rise is high in the first cycle d is 1 after a 0.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= 1'b0;
    end else begin
      r_d <= d;
    end
  end

  assign rise = d & ~r_d;

endmodule

// File: rtl/ping_echo_meter.sv
// Fires one transmit burst per start strobe, then times the first echo edge and counts edges.
// Optional PING_BLANK_EN ignores edges during the early part of the listen window.
module ping_echo_meter
  import ping_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int WIN       = DEF_WIN,
  parameter int BLANK     = DEF_BLANK,
  parameter int CNT_W     = $clog2(WIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sig,
  output logic              tx_en,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              timeout,
  output logic              result_valid
);

  // Elaboration-time guard on the window geometry.
  if ((WIN <= BURST_LEN + BLANK) || ((WIN & (WIN - 1)) != 0)) begin : g_bad_cfg
    $error("ping_echo_meter: WIN must be a power of two larger than BURST_LEN+BLANK");
  end

  localparam logic [CNT_W-1:0] LP_BURST_END  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LP_LISTEN_END = CNT_W'(WIN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_cap;
  logic              r_first;
  logic [EDGE_W-1:0] r_ecnt;

  logic              r_tx_en;
  logic              r_busy;
  logic [CNT_W-1:0]  r_result;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic              r_timeout;
  logic              r_valid;

  logic              w_rise;
  logic              w_qual;
  logic              w_first_nxt;
  logic [CNT_W-1:0]  w_cap_nxt;
  logic [EDGE_W-1:0] w_ecnt_nxt;
  logic              w_launch;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (sig),
    .rise (w_rise)
  );

`ifdef PING_BLANK_EN
  localparam logic [CNT_W-1:0] LP_BLANK_END = CNT_W'(BURST_LEN + BLANK);
  assign w_qual = (r_state == ST_LISTEN) & w_rise & (r_cnt >= LP_BLANK_END);
`else
  assign w_qual = (r_state == ST_LISTEN) & w_rise;
`endif

  assign w_launch = (r_state == ST_IDLE) & start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_BURST;
      ST_BURST:  if (r_cnt == LP_BURST_END) w_state_nxt = ST_LISTEN;
      ST_LISTEN: if (r_cnt == LP_LISTEN_END) w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Updated working values; the report uses these so an edge in the last cycle still lands.
  always_comb begin
    w_first_nxt = r_first | w_qual;
    w_cap_nxt   = (w_qual & ~r_first) ? r_cnt : r_cap;
    w_ecnt_nxt  = w_qual ? edge_inc(r_ecnt) : r_ecnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx_en <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_en <= (w_state_nxt == ST_BURST);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_valid <= (w_state_nxt == ST_REPORT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cap   <= '0;
      r_first <= 1'b0;
      r_ecnt  <= '0;
    end else if (w_launch) begin
      r_cnt   <= '0;
      r_cap   <= '0;
      r_first <= 1'b0;
      r_ecnt  <= '0;
    end else begin
      // Hold the counter once the window closes so it never wraps.
      if ((w_state_nxt == ST_BURST) || (w_state_nxt == ST_LISTEN)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_cap   <= w_cap_nxt;
      r_first <= w_first_nxt;
      r_ecnt  <= w_ecnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_edge_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_state_nxt == ST_REPORT) begin
      r_result   <= w_first_nxt ? w_cap_nxt : '1;
      r_edge_cnt <= w_ecnt_nxt;
      r_timeout  <= ~w_first_nxt;
    end
  end

  assign tx_en        = r_tx_en;
  assign busy         = r_busy;
  assign result       = r_result;
  assign edge_cnt     = r_edge_cnt;
  assign timeout      = r_timeout;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_ping_echo_meter.sv
// Bench for ping_echo_meter: table of sig profiles with expected reports, scoreboard on result_valid.
module tb_ping_echo_meter;

  localparam int BL = 16;
  localparam int WN = 64;
  localparam int BK = 4;
  localparam int CW = 6;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sig;
  logic          tx_en;
  logic          busy;
  logic [CW-1:0] result;
  logic [7:0]    edge_cnt;
  logic          timeout;
  logic          result_valid;

  always #5 clk = ~clk;

  ping_echo_meter #(
    .BURST_LEN (BL),
    .WIN       (WN),
    .BLANK     (BK),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sig          (sig),
    .tx_en        (tx_en),
    .busy         (busy),
    .result       (result),
    .edge_cnt     (edge_cnt),
    .timeout      (timeout),
    .result_valid (result_valid)
  );

  typedef struct {
    string       nm;
    logic [63:0] prof;     // sig value during the cycle whose counter equals the bit index
    int          xs0;      // extra start strobes at these counters (-1 = none)
    int          xs1;
    int          rst_at;   // assert rst at this counter (-1 = none)
    bit          has_res;
    int          e_res;
    int          e_cnt;
    bit          e_to;
  } vec_t;

  typedef struct {
    string nm;
    int    res;
    int    cnt;
    bit    to;
  } exp_t;

  exp_t sbq[$];
  vec_t tv[NV];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   rv_seen = 0;
  int   n_push  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [63:0] mk(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mkv(input string nm, input logic [63:0] p, input int xs0,
                               input int xs1, input int ra, input bit hr,
                               input int er, input int ec, input bit et);
    vec_t v;
    v.nm = nm; v.prof = p; v.xs0 = xs0; v.xs1 = xs1; v.rst_at = ra;
    v.has_res = hr; v.e_res = er; v.e_cnt = ec; v.e_to = et;
    return v;
  endfunction

  // Scoreboard: every result_valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      rv_seen++;
      if (sbq.size() == 0) begin
        chk("unexpected_result_valid_pending", sbq.size(), 1);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_result"}, int'(result), e.res);
        chk({e.nm, "_edge_cnt"}, int'(edge_cnt), e.cnt);
        chk({e.nm, "_timeout"}, int'(timeout), int'(e.to));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int rv0;
    bit aborted;
    exp_t e;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sig   = 1'b0;
    if (v.has_res) begin
      e.nm = v.nm; e.res = v.e_res; e.cnt = v.e_cnt; e.to = v.e_to;
      sbq.push_back(e);
      n_push++;
    end
    @(posedge clk);
    for (int k = 0; k < WN && !aborted; k++) begin
      @(negedge clk);
      start = (k == v.xs0) || (k == v.xs1);
      sig   = v.prof[k];
      rst   = (k == v.rst_at);
      chk($sformatf("%s_tx_en_c%0d", v.nm, k), int'(tx_en), (k < BL) ? 1 : 0);
      chk($sformatf("%s_busy_c%0d", v.nm, k), int'(busy), 1);
      chk($sformatf("%s_rv_c%0d", v.nm, k), int'(result_valid), 0);
      if (k == v.rst_at) begin
        @(negedge clk);
        rst = 1'b0; start = 1'b0; sig = 1'b0;
        chk({v.nm, "_post_rst_tx_en"}, int'(tx_en), 0);
        chk({v.nm, "_post_rst_busy"}, int'(busy), 0);
        chk({v.nm, "_post_rst_result"}, int'(result), 0);
        chk({v.nm, "_post_rst_edge_cnt"}, int'(edge_cnt), 0);
        chk({v.nm, "_post_rst_timeout"}, int'(timeout), 0);
        chk({v.nm, "_post_rst_rv"}, int'(result_valid), 0);
        rv0 = rv_seen;
        repeat (WN + 4) @(negedge clk);
        chk({v.nm, "_no_rv_after_rst"}, rv_seen, rv0);
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      start = 1'b0; sig = 1'b0;
      chk({v.nm, "_rv_at_report"}, int'(result_valid), 1);
      chk({v.nm, "_busy_at_report"}, int'(busy), 1);
      chk({v.nm, "_tx_en_at_report"}, int'(tx_en), 0);
      @(negedge clk);
      chk({v.nm, "_rv_after_report"}, int'(result_valid), 0);
      chk({v.nm, "_busy_after_report"}, int'(busy), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    tv[0] = mkv("rise30", mk(30, 35), -1, -1, -1, 1'b1, 30, 1, 1'b0);
    tv[1] = mkv("silent", '0, -1, -1, -1, 1'b1, 63, 0, 1'b1);
`ifdef PING_BLANK_EN
    tv[2] = mkv("edge18", mk(18, 19), -1, -1, -1, 1'b1, 63, 0, 1'b1);
`else
    tv[2] = mkv("edge18", mk(18, 19), -1, -1, -1, 1'b1, 18, 1, 1'b0);
`endif
    tv[3] = mkv("multi", mk(20, 20) | mk(30, 30) | mk(40, 40) | mk(63, 63),
                5, 50, -1, 1'b1, 20, 4, 1'b0);
    tv[4] = mkv("rst10", mk(30, 35), -1, -1, 10, 1'b0, 0, 0, 1'b0);
    tv[5] = mkv("rise30_again", mk(30, 35), -1, -1, -1, 1'b1, 30, 1, 1'b0);
    tv[6] = mkv("held_high", mk(12, 63), -1, -1, -1, 1'b1, 63, 0, 1'b1);
`ifdef PING_BLANK_EN
    tv[7] = mkv("edge16", mk(16, 16), -1, -1, -1, 1'b1, 63, 0, 1'b1);
    tv[9] = mkv("edge18_25", mk(18, 18) | mk(25, 26), -1, -1, -1, 1'b1, 25, 1, 1'b0);
`else
    tv[7] = mkv("edge16", mk(16, 16), -1, -1, -1, 1'b1, 16, 1, 1'b0);
    tv[9] = mkv("edge18_25", mk(18, 18) | mk(25, 26), -1, -1, -1, 1'b1, 18, 2, 1'b0);
`endif
    tv[8] = mkv("edge63", mk(63, 63), -1, -1, -1, 1'b1, 63, 1, 1'b0);

    rst = 1'b1; start = 1'b0; sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_en", int'(tx_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_edge_cnt", int'(edge_cnt), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_rv", int'(result_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(tv[i]);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("result_valid_total", rv_seen, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
